camera_rd_packer: RTL and testbench

Packs the camera pixel stream into 32-bit words and buffers them for the host read pipe. It sits directly upstream of the PCIe core's `user_r_rd_*` FIFO interface and drives `rd_data`/`rd_empty`/`rd_eof` from its `rd_rden`/`rd_open` strobes. Capture is frame-aligned: whole frames only, starting at the first start-of-frame after the pipe is opened. Overflow drops the remainder of a frame rather than corrupting later frames.

---
 rtl/camera_pkg.sv | 15 +
 rtl/camera_rd_packer_if.sv | 25 ++
 rtl/camera_pack_fifo.sv | 69 ++++++
 rtl/camera_rd_packer.sv | 158 +++++++++++++++
 tb/tb_camera_rd_packer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_pkg.sv
// Shared widths and the packer state encoding for the camera read path.
// DONE exists only when CAMERA_PACK_EOF_EN is defined (one frame per host open).
package camera_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

`ifdef CAMERA_PACK_EOF_EN
  typedef enum logic [2:0] {IDLE, WAIT_SOF, CAPTURE, DROP, DONE} pack_state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_SOF, CAPTURE, DROP} pack_state_t;
`endif

endpackage

// File: rtl/camera_rd_packer_if.sv
// Pixel stream in, host read-pipe FIFO port out; master is the camera/host side,
// slave is the packer.
interface camera_rd_packer_if;

  logic [camera_pkg::PIX_W-1:0]  pix_data;
  logic                          pix_valid;
  logic                          pix_sof;
  logic                          pix_eof;
  logic                          rd_open;
  logic                          rd_rden;
  logic [camera_pkg::WORD_W-1:0] rd_data;
  logic                          rd_empty;
  logic                          rd_eof;

  modport master (
    output pix_data, pix_valid, pix_sof, pix_eof, rd_open, rd_rden,
    input  rd_data, rd_empty, rd_eof
  );

  modport slave (
    input  pix_data, pix_valid, pix_sof, pix_eof, rd_open, rd_rden,
    output rd_data, rd_empty, rd_eof
  );

endinterface

// File: rtl/camera_pack_fifo.sv
// Synchronous FIFO, depth 2^ADDR_W, registered read data one cycle after rd_en.
// Writes at full succeed only alongside a pop; full/empty are registered from the count.
module camera_pack_fifo #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              do_wr, do_rd;

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    cnt_nxt = cnt;
    if (do_wr && !do_rd)
      cnt_nxt = cnt + (ADDR_W+1)'(1);
    else if (!do_wr && do_rd)
      cnt_nxt = cnt - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else if (flush) begin
      // rd_data keeps its last value so the host never sees a spurious word change
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CNT_MAX);
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/camera_rd_packer.sv
// Packs 8-bit pixels little-endian into 32-bit words for the host read FIFO; word written
// the cycle after its last pixel. No camera backpressure: a full FIFO drops the rest of the frame.
// Macro CAMERA_PACK_EOF_EN: stop after one frame per open and raise rd_eof once drained.
module camera_rd_packer
  import camera_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  camera_rd_packer_if.slave rif,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES-1);

`ifdef CAMERA_PACK_EOF_EN
  localparam pack_state_t EOF_STATE = DONE;
`else
  localparam pack_state_t EOF_STATE = WAIT_SOF;
`endif

  pack_state_t       state;
  logic [LANE_W-1:0] lane, lane_use;
  logic [WORD_W-1:0] word_q, word_nxt, wr_dat, fifo_rd_data;
  logic              wr_vld, wr_last, take_pix;
  logic              fifo_full, fifo_empty, pop, wr_ok, drop_now;

  assign pop      = rif.rd_rden & ~fifo_empty;
  assign wr_ok    = ~fifo_full | pop;
  assign drop_now = wr_vld & ~wr_ok;

  // A sof pixel always lands in lane 0, discarding any partial word.
  always_comb begin
    take_pix = 1'b0;
    lane_use = lane;
    case (state)
      WAIT_SOF: begin
        take_pix = rif.pix_valid & rif.pix_sof;
        lane_use = '0;
      end
      CAPTURE: begin
        take_pix = rif.pix_valid;
        if (rif.pix_sof)
          lane_use = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    word_nxt = word_q;
    case (lane_use)
      2'd0:    word_nxt = {{(WORD_W-PIX_W){1'b0}}, rif.pix_data};
      2'd1:    word_nxt = {{(WORD_W-2*PIX_W){1'b0}}, rif.pix_data, word_q[PIX_W-1:0]};
      2'd2:    word_nxt = {{PIX_W{1'b0}}, rif.pix_data, word_q[2*PIX_W-1:0]};
      default: word_nxt = {rif.pix_data, word_q[3*PIX_W-1:0]};
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state    <= IDLE;
      lane     <= '0;
      word_q   <= '0;
      wr_dat   <= '0;
      wr_vld   <= 1'b0;
      wr_last  <= 1'b0;
      overflow <= 1'b0;
    end else if (!rif.rd_open) begin
      state    <= IDLE;
      lane     <= '0;
      wr_vld   <= 1'b0;
      wr_last  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_vld  <= 1'b0;
      wr_last <= 1'b0;
      if (state == IDLE)
        state <= WAIT_SOF;

      if (take_pix) begin
        word_q <= word_nxt;
        if (rif.pix_eof || lane_use == LAST_LANE) begin
          wr_vld  <= 1'b1;
          wr_dat  <= word_nxt;
          wr_last <= rif.pix_eof;
          lane    <= '0;
        end else begin
          lane <= lane_use + LANE_W'(1);
        end
        state <= rif.pix_eof ? EOF_STATE : CAPTURE;
      end else if (state == DROP && rif.pix_valid && rif.pix_eof) begin
        state <= WAIT_SOF;
      end

      // Full is judged in the write cycle; the pixel arriving now belongs to the lost frame.
      if (drop_now) begin
        overflow <= 1'b1;
        wr_vld   <= 1'b0;
        if (!wr_last) begin
          lane  <= '0;
          state <= (rif.pix_valid && rif.pix_eof) ? WAIT_SOF : DROP;
        end
`ifdef CAMERA_PACK_EOF_EN
        else if (state == DONE) begin
          state <= WAIT_SOF;
        end
`endif
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst)
      frame_cnt <= '0;
    else if (wr_vld && wr_ok && wr_last)
      frame_cnt <= frame_cnt + CNT_W'(1);
  end

`ifdef CAMERA_PACK_EOF_EN
  logic rd_eof_q;

  // Wait for the final word to have been written before judging the FIFO drained.
  always_ff @(posedge bus_clk) begin
    if (bus_rst || !rif.rd_open)
      rd_eof_q <= 1'b0;
    else
      rd_eof_q <= (state == DONE) && fifo_empty && !wr_vld;
  end

  assign rif.rd_eof = rd_eof_q;
`else
  assign rif.rd_eof = 1'b0;
`endif

  camera_pack_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_fifo (
    .clk     (bus_clk),
    .rst     (bus_rst),
    .flush   (state == IDLE),
    .wr_en   (wr_vld),
    .wr_data (wr_dat),
    .rd_en   (rif.rd_rden),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rif.rd_data  = fifo_rd_data;
  assign rif.rd_empty = fifo_empty;

endmodule

// File: tb/tb_camera_rd_packer.sv
// Bench for camera_rd_packer with a 4-word FIFO: frame table plus hand-written corner sequences.
module tb_camera_rd_packer;

  logic        bus_clk;
  logic        bus_rst;
  logic        overflow;
  logic [15:0] frame_cnt;

  camera_rd_packer_if rif();

  camera_rd_packer #(
    .ADDR_W (2),
    .CNT_W  (16)
  ) dut (
    .bus_clk   (bus_clk),
    .bus_rst   (bus_rst),
    .rif       (rif),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [7:0]  base;
    int          len;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t        tv [5];
  logic [31:0] exp_q [$];
  logic [31:0] last_w;
  logic [15:0] exp_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  initial begin
    bus_clk = 1'b0;
    forever #5 bus_clk = ~bus_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic pix1(input logic [7:0] d, input logic s, input logic e);
    rif.pix_valid = 1'b1;
    rif.pix_data  = d;
    rif.pix_sof   = s;
    rif.pix_eof   = e;
    tick();
  endtask

  task automatic pix_idle();
    rif.pix_valid = 1'b0;
    rif.pix_sof   = 1'b0;
    rif.pix_eof   = 1'b0;
    rif.pix_data  = 8'h00;
  endtask

  task automatic send(input logic [7:0] base, input int len, input bit chk_lat);
    for (int k = 0; k < len; k++) begin
      pix1(base + 8'(k), k == 0, k == len - 1);
      if (chk_lat && k == 3) chk("empty_at_n1", {31'b0, rif.rd_empty}, 32'd1);
      if (chk_lat && k == 4) chk("empty_at_n2", {31'b0, rif.rd_empty}, 32'd0);
    end
    pix_idle();
  endtask

  task automatic reopen();
    rif.rd_open = 1'b0;
    tick();
    tick();
    rif.rd_open = 1'b1;
    tick();
    tick();
  endtask

  task automatic drain();
    int          guard;
    logic [31:0] w;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      guard++;
      if (!rif.rd_empty) begin
        rif.rd_rden = 1'b1;
        tick();
        rif.rd_rden = 1'b0;
        w = exp_q.pop_front();
        chk("rd_data", rif.rd_data, w);
        last_w = w;
      end else begin
        tick();
      end
    end
    chk("words_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    chk("empty_after_drain", {31'b0, rif.rd_empty}, 32'd1);
  endtask

  initial begin
    tv[0] = '{8'h01, 8, 2, 32'h04030201, 32'h08070605};
    tv[1] = '{8'hA0, 6, 2, 32'hA3A2A1A0, 32'h0000A5A4};
    tv[2] = '{8'h55, 1, 1, 32'h00000055, 32'h00000000};
    tv[3] = '{8'h10, 3, 1, 32'h00121110, 32'h00000000};
    tv[4] = '{8'hF0, 4, 1, 32'hF3F2F1F0, 32'h00000000};

    bus_rst     = 1'b1;
    rif.rd_open = 1'b0;
    rif.rd_rden = 1'b0;
    pix_idle();
    exp_cnt = '0;
    last_w  = '0;
    repeat (3) tick();
    chk("rst_rd_data", rif.rd_data, 32'h0);
    chk("rst_rd_empty", {31'b0, rif.rd_empty}, 32'd1);
    chk("rst_rd_eof", {31'b0, rif.rd_eof}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    bus_rst = 1'b0;
    tick();

    // Table of single frames, each in its own open so both build variants apply.
    for (int i = 0; i < 5; i++) begin
      reopen();
      exp_q.push_back(tv[i].w0);
      if (tv[i].nw > 1) exp_q.push_back(tv[i].w1);
      send(tv[i].base, tv[i].len, i == 0);
      exp_cnt++;
      tick();
      tick();
      chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, exp_cnt});
      drain();
      repeat (3) tick();
`ifdef CAMERA_PACK_EOF_EN
      chk("rd_eof_done", {31'b0, rif.rd_eof}, 32'd1);
`else
      chk("rd_eof_off", {31'b0, rif.rd_eof}, 32'd0);
`endif
    end

    // Reads while empty leave rd_data alone.
    rif.rd_rden = 1'b1;
    tick();
    tick();
    rif.rd_rden = 1'b0;
    chk("hold_rd_data", rif.rd_data, last_w);
    chk("hold_rd_empty", {31'b0, rif.rd_empty}, 32'd1);

    // Pre-sof pixels ignored; a sof mid-frame restarts at lane 0.
    reopen();
    pix1(8'hE0, 1'b0, 1'b0);
    pix1(8'hE1, 1'b0, 1'b0);
    pix1(8'hE2, 1'b0, 1'b1);
    pix1(8'h30, 1'b1, 1'b0);
    pix1(8'h31, 1'b0, 1'b0);
    pix1(8'h40, 1'b1, 1'b0);
    pix1(8'h41, 1'b0, 1'b0);
    pix1(8'h42, 1'b0, 1'b0);
    pix1(8'h43, 1'b0, 1'b0);
    pix1(8'h44, 1'b0, 1'b1);
    pix_idle();
    exp_q.push_back(32'h43424140);
    exp_q.push_back(32'h00000044);
    exp_cnt++;
    tick();
    tick();
    chk("restart_frame_cnt", {16'b0, frame_cnt}, {16'b0, exp_cnt});
    chk("restart_overflow", {31'b0, overflow}, 32'd0);
    drain();

    // Back-to-back frames: continuous capture, or one frame per open with rd_eof.
    reopen();
    exp_q.push_back(32'h63626160);
    send(8'h60, 4, 1'b0);
`ifndef CAMERA_PACK_EOF_EN
    exp_q.push_back(32'h73727170);
    exp_cnt++;
`endif
    send(8'h70, 4, 1'b0);
    exp_cnt++;
    tick();
    tick();
    chk("b2b_frame_cnt", {16'b0, frame_cnt}, {16'b0, exp_cnt});
    drain();
    repeat (3) tick();
`ifdef CAMERA_PACK_EOF_EN
    chk("b2b_rd_eof", {31'b0, rif.rd_eof}, 32'd1);
`else
    chk("b2b_rd_eof", {31'b0, rif.rd_eof}, 32'd0);
`endif
    reopen();
    chk("reopen_rd_eof", {31'b0, rif.rd_eof}, 32'd0);
    exp_q.push_back(32'hB3B2B1B0);
    send(8'hB0, 4, 1'b0);
    exp_cnt++;
    drain();
    chk("reopen_frame_cnt", {16'b0, frame_cnt}, {16'b0, exp_cnt});

    // Overflow: 24-pixel frame into 4 words, next frame lost, then space frees up.
    reopen();
    exp_q.push_back(32'h03020100);
    exp_q.push_back(32'h07060504);
    exp_q.push_back(32'h0B0A0908);
    exp_q.push_back(32'h0F0E0D0C);
    send(8'h00, 24, 1'b0);
    tick();
    tick();
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    chk("ovf_frame_cnt", {16'b0, frame_cnt}, {16'b0, exp_cnt});
    send(8'h80, 4, 1'b0);
    tick();
    tick();
    chk("ovf_next_frame_cnt", {16'b0, frame_cnt}, {16'b0, exp_cnt});
    drain();
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    exp_q.push_back(32'h93929190);
    send(8'h90, 4, 1'b0);
    exp_cnt++;
    drain();
    chk("ovf_recover_cnt", {16'b0, frame_cnt}, {16'b0, exp_cnt});

    // A pop in the write cycle at full makes room: no drop.
    reopen();
    exp_q.push_back(32'h23222120);
    exp_q.push_back(32'h27262524);
    exp_q.push_back(32'h2B2A2928);
    exp_q.push_back(32'h2F2E2D2C);
    exp_q.push_back(32'h33323130);
    send(8'h20, 20, 1'b0);
    rif.rd_rden = 1'b1;
    tick();
    rif.rd_rden = 1'b0;
    last_w = exp_q.pop_front();
    chk("full_pop_data", rif.rd_data, last_w);
    exp_cnt++;
    tick();
    chk("full_pop_overflow", {31'b0, overflow}, 32'd0);
    chk("full_pop_frame_cnt", {16'b0, frame_cnt}, {16'b0, exp_cnt});
    drain();

    // Reset in the middle of a frame, then a fresh frame after reopen.
    reopen();
    pix1(8'hD0, 1'b1, 1'b0);
    for (int k = 1; k < 6; k++) pix1(8'hD0 + 8'(k), 1'b0, 1'b0);
    pix_idle();
    tick();
    bus_rst = 1'b1;
    tick();
    chk("mid_rst_rd_data", rif.rd_data, 32'h0);
    chk("mid_rst_rd_empty", {31'b0, rif.rd_empty}, 32'd1);
    chk("mid_rst_rd_eof", {31'b0, rif.rd_eof}, 32'd0);
    chk("mid_rst_overflow", {31'b0, overflow}, 32'd0);
    chk("mid_rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    bus_rst = 1'b0;
    exp_cnt = '0;
    exp_q.delete();
    reopen();
    exp_q.push_back(32'hC3C2C1C0);
    send(8'hC0, 4, 1'b0);
    exp_cnt++;
    drain();
    chk("post_rst_frame_cnt", {16'b0, frame_cnt}, {16'b0, exp_cnt});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
